// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPIMaster between NUM_REQ requesters; owns the slave-select bus.
// Optional XFER watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for a request; grants round-robin from the priority pointer
//   SETUP | grant held; asserts the selected slave select, or finishes with error on a bad byte count
//   XFER  | SPIMaster enabled until its read fill level reaches the latched byte count
//   DONE  | completion pulse, read data captured, fill level reset, selects released
//   GAP   | all selects deasserted for GAP_CYCLES before the next grant
module spi_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*32-1:0] wdata_i,
    input  logic [NUM_REQ*3-1:0] bytes_i,
    input  logic [NUM_REQ*5-1:0] ss_sel_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 err_o,
    output logic [31:0]          rdata_o,
    output logic                 spi_enable_o,
    output logic [31:0]          spi_wdata_o,
    output logic [2:0]           spi_bytes_o,
    output logic                 spi_reset_fill_o,
    input  logic [31:0]          spi_rdata_i,
    input  logic [2:0]           spi_rbytes_i,
    output logic [31:0]          spi_ss_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] arb_idx;
    logic [IDXW-1:0] cand_idx;
    logic            arb_found;
    logic [31:0]     sel_wdata;
    logic [2:0]      sel_bytes;
    logic [4:0]      sel_ss;
    logic [4:0]      lat_ss;
    logic            bad_cnt;
    logic [3:0]      gap_cnt;
    logic            timeout_hit;
    logic            fin_now;
    logic            fin_err;
    int              cand;

    // Scan upward from the pointer; the first active request wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        sel_wdata = '0;
        sel_bytes = '0;
        sel_ss    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDXW'(cand);
            if (!arb_found && req_i[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IDXW'(k)) begin
                sel_wdata = wdata_i[k*32 +: 32];
                sel_bytes = bytes_i[k*3 +: 3];
                sel_ss    = ss_sel_i[k*5 +: 5];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;

    // Down-counter loaded while entering XFER; terminal count means TIMEOUT_CYCLES XFER cycles elapsed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wd_cnt <= WDW'(TIMEOUT_CYCLES - 1);
        end else if (state == ST_XFER && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign timeout_hit = (state == ST_XFER) && (wd_cnt == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    // A real completion wins over a coincident timeout.
    always_comb begin
        fin_now = 1'b0;
        fin_err = 1'b0;
        if (state == ST_SETUP && bad_cnt) begin
            fin_now = 1'b1;
            fin_err = 1'b1;
        end else if (state == ST_XFER) begin
            if (spi_rbytes_i == spi_bytes_o) begin
                fin_now = 1'b1;
            end else if (timeout_hit) begin
                fin_now = 1'b1;
                fin_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            gnt_o            <= '0;
            done_o           <= '0;
            err_o            <= 1'b0;
            rdata_o          <= '0;
            spi_enable_o     <= 1'b0;
            spi_wdata_o      <= '0;
            spi_bytes_o      <= '0;
            spi_reset_fill_o <= 1'b0;
            spi_ss_o         <= 32'hFFFF_FFFF;
            lat_ss           <= '0;
            bad_cnt          <= 1'b0;
            gap_cnt          <= '0;
        end else if (fin_now) begin
            done_o           <= gnt_o;
            err_o            <= fin_err;
            rdata_o          <= spi_rdata_i;
            spi_reset_fill_o <= 1'b1;
            spi_enable_o     <= 1'b0;
            spi_ss_o         <= 32'hFFFF_FFFF;
            gnt_o            <= '0;
            state            <= ST_DONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        gnt_o       <= NUM_REQ'(1) << arb_idx;
                        ptr         <= (arb_idx == IDXW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        spi_wdata_o <= sel_wdata;
                        spi_bytes_o <= sel_bytes;
                        lat_ss      <= sel_ss;
                        bad_cnt     <= (sel_bytes == 3'd0) || (sel_bytes > 3'd4);
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    spi_ss_o <= ~(32'd1 << lat_ss);
                    state    <= ST_XFER;
                end
                ST_XFER: begin
                    spi_enable_o <= 1'b1;
                end
                ST_DONE: begin
                    done_o           <= '0;
                    err_o            <= 1'b0;
                    spi_reset_fill_o <= 1'b0;
                    gap_cnt          <= 4'(GAP_CYCLES - 1);
                    state            <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (2 requesters, GAP_CYCLES=2, TIMEOUT_CYCLES=16).
// The timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined; otherwise XFER must hang.
module tb_spi_arbiter;

    localparam int NR = 2;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*32-1:0] wdata;
    logic [NR*3-1:0] bytes_v;
    logic [NR*5-1:0] ss_sel;
    logic [NR-1:0]   gnt_o;
    logic [NR-1:0]   done_o;
    logic            err_o;
    logic [31:0]     rdata_o;
    logic            spi_enable_o;
    logic [31:0]     spi_wdata_o;
    logic [2:0]      spi_bytes_o;
    logic            spi_reset_fill_o;
    logic [31:0]     spi_rdata;
    logic [2:0]      spi_rbytes;
    logic [31:0]     spi_ss_o;

    int checks   = 0;
    int failures = 0;

    spi_arbiter #(
        .NUM_REQ        (NR),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .wdata_i          (wdata),
        .bytes_i          (bytes_v),
        .ss_sel_i         (ss_sel),
        .gnt_o            (gnt_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .rdata_o          (rdata_o),
        .spi_enable_o     (spi_enable_o),
        .spi_wdata_o      (spi_wdata_o),
        .spi_bytes_o      (spi_bytes_o),
        .spi_reset_fill_o (spi_reset_fill_o),
        .spi_rdata_i      (spi_rdata),
        .spi_rbytes_i     (spi_rbytes),
        .spi_ss_o         (spi_ss_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (gnt_o == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("wait_gnt_bound", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_g;
        int          e;

        rst        = 1'b1;
        req        = '0;
        wdata      = '0;
        bytes_v    = '0;
        ss_sel     = '0;
        spi_rdata  = '0;
        spi_rbytes = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ss",    spi_ss_o, 32'hFFFF_FFFF);
        chk("rst_gnt",   32'(gnt_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_en",    32'(spi_enable_o), 32'd0);
        chk("rst_fill",  32'(spi_reset_fill_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_wdata", spi_wdata_o, 32'd0);
        chk("rst_bytes", 32'(spi_bytes_o), 32'd0);
        rst = 1'b0;

        // Single legal transfer: requester 0, 2 bytes, slave 3
        wdata  = {32'h0, 32'hA5C3_0F11};
        bytes_v = {3'd0, 3'd2};
        ss_sel = {5'd0, 5'd3};
        req    = 2'b01;
        tick();
        chk("t1_gnt", 32'(gnt_o), 32'd1);
        chk("t1_ss_pre", spi_ss_o, 32'hFFFF_FFFF);
        tick();
        chk("t1_ss_setup", spi_ss_o, 32'hFFFF_FFF7);
        chk("t1_wdata", spi_wdata_o, 32'hA5C3_0F11);
        chk("t1_bytes", 32'(spi_bytes_o), 32'd2);
        chk("t1_en_setup", 32'(spi_enable_o), 32'd0);
        tick();
        chk("t1_en_xfer", 32'(spi_enable_o), 32'd1);
        tick();
        tick();
        chk("t1_no_done", 32'(done_o), 32'd0);
        chk("t1_ss_xfer", spi_ss_o, 32'hFFFF_FFF7);
        spi_rbytes = 3'd2;
        spi_rdata  = 32'h1234_ABCD;
        tick();
        chk("t1_done",  32'(done_o), 32'd1);
        chk("t1_err",   32'(err_o), 32'd0);
        chk("t1_rdata", rdata_o, 32'h1234_ABCD);
        chk("t1_ss_done", spi_ss_o, 32'hFFFF_FFFF);
        chk("t1_gnt_clr", 32'(gnt_o), 32'd0);
        chk("t1_en_clr", 32'(spi_enable_o), 32'd0);
        chk("t1_fill", 32'(spi_reset_fill_o), 32'd1);
        spi_rbytes = 3'd0;
        req        = 2'b00;
        tick();
        chk("t1_done_pulse", 32'(done_o), 32'd0);
        chk("t1_fill_pulse", 32'(spi_reset_fill_o), 32'd0);
        chk("t1_gap1_ss", spi_ss_o, 32'hFFFF_FFFF);
        tick();
        chk("t1_gap2_ss", spi_ss_o, 32'hFFFF_FFFF);
        chk("t1_rdata_hold", rdata_o, 32'h1234_ABCD);

        // Illegal byte count on requester 1 (pointer now 1)
        bytes_v = {3'd5, 3'd2};
        req     = 2'b10;
        wait_gnt();
        chk("ill_gnt", 32'(gnt_o), 32'd2);
        tick();
        chk("ill_done", 32'(done_o), 32'd2);
        chk("ill_err",  32'(err_o), 32'd1);
        chk("ill_en",   32'(spi_enable_o), 32'd0);
        chk("ill_ss",   spi_ss_o, 32'hFFFF_FFFF);
        req = 2'b00;
        tick();
        chk("ill_err_clr", 32'(err_o), 32'd0);

        // Reset mid-XFER; requester 0 granted so pointer moves to 1 beforehand
        bytes_v = {3'd3, 3'd4};
        ss_sel  = {5'd5, 5'd31};
        req     = 2'b01;
        wait_gnt();
        chk("rx_gnt", 32'(gnt_o), 32'd1);
        tick();
        chk("rx_ss", spi_ss_o, 32'h7FFF_FFFF);
        tick();
        tick();
        tick();
        chk("rx_en", 32'(spi_enable_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("rx_ss_rst",  spi_ss_o, 32'hFFFF_FFFF);
        chk("rx_en_rst",  32'(spi_enable_o), 32'd0);
        chk("rx_gnt_rst", 32'(gnt_o), 32'd0);
        rst     = 1'b0;
        bytes_v = {3'd3, 3'd1};
        ss_sel  = {5'd5, 5'd0};
        req     = 2'b11;
        wait_gnt();

        // Fairness: both requesters held high for 4 transfers
        for (int i = 0; i < 4; i++) begin
            e     = i % 2;
            exp_g = (e == 0) ? 32'd1 : 32'd2;
            chk("fair_gnt", 32'(gnt_o), exp_g);
            chk("fair_onehot", $onehot(gnt_o) ? 32'd1 : 32'd0, 32'd1);
            tick();
            chk("fair_ss", spi_ss_o, (e == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFDF);
            tick();
            chk("fair_en", 32'(spi_enable_o), 32'd1);
            spi_rbytes = (e == 0) ? 3'd1 : 3'd3;
            spi_rdata  = 32'hC0DE_0000 + 32'(i);
            tick();
            chk("fair_done", 32'(done_o), exp_g);
            chk("fair_rdata", rdata_o, 32'hC0DE_0000 + 32'(i));
            spi_rbytes = 3'd0;
            if (i < 3) wait_gnt();
        end
        req = 2'b00;

        // Model never completes the transfer
        bytes_v   = {3'd3, 3'd2};
        spi_rdata = 32'h0BAD_F00D;
        req       = 2'b01;
        wait_gnt();
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        chk("tmo_early", 32'(done_o), 32'd0);
        tick();
        chk("tmo_done",  32'(done_o), 32'd1);
        chk("tmo_err",   32'(err_o), 32'd1);
        chk("tmo_rdata", rdata_o, 32'h0BAD_F00D);
        chk("tmo_fill",  32'(spi_reset_fill_o), 32'd1);
        req = 2'b00;
        tick();
        chk("tmo_fill_once", 32'(spi_reset_fill_o), 32'd0);
`else
        for (int i = 0; i < 30; i++) tick();
        chk("hang_done", 32'(done_o), 32'd0);
        chk("hang_en",   32'(spi_enable_o), 32'd1);
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        chk("hang_rst_ss", spi_ss_o, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
